// File: rtl/k6502_defs_pkg.sv
// Shared 6502-core definitions: ALU op codes, status-register bit indices,
// the status reset value and the ALU controller state type.
package k6502_defs_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_ORA = 4'h3;
    localparam logic [3:0] OP_EOR = 4'h4;
    localparam logic [3:0] OP_INC = 4'h5;
    localparam logic [3:0] OP_DEC = 4'h6;
    localparam logic [3:0] OP_TST = 4'h7;
    localparam logic [3:0] OP_DAD = 4'h8;

    localparam int SR_C = 0;
    localparam int SR_Z = 1;
    localparam int SR_I = 2;
    localparam int SR_D = 3;
    localparam int SR_B = 4;
    localparam int SR_U = 5;
    localparam int SR_V = 6;
    localparam int SR_N = 7;

    localparam logic [7:0] SR_RESET = 8'h24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS_LO,
        ST_PASS_HI,
        ST_DONE
    } ctl_state_t;

    // Bit 5 of the status register is hard-wired to 1 on every write path.
    function automatic logic [7:0] with_u(input logic [7:0] s);
        return s | (8'(1) << SR_U);
    endfunction

endpackage

// File: rtl/alu_ctl.sv
// ALU sequencer: runs one narrow ALU pass or a two-pass 16-bit address add,
// captures the result and merges masked flags into the status register.
module alu_ctl
    import k6502_defs_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wide,
    input  logic [3:0]  op_in,
    input  logic [2:0]  sel_in,
    input  logic [2:0]  sel_hi,
    input  logic [7:0]  operand,
    input  logic [7:0]  flag_mask,
    input  logic        sr_we,
    input  logic [7:0]  sr_in,
    output logic [3:0]  alu_op,
    output logic [2:0]  alu_sel,
    output logic [7:0]  alu_din,
    input  logic [7:0]  alu_dout,
    input  logic [7:0]  alu_flags,
    output logic [7:0]  sr,
    output logic [15:0] result,
    output logic        busy,
    output logic        done,
    output logic        page_cross
);

    ctl_state_t state, state_nx;

    logic       wide_q;
    logic [3:0] op_q;
    logic [2:0] sel_lo_q;
    logic [2:0] sel_hi_q;
    logic [7:0] operand_q;
    logic [7:0] mask_q;
    logic       carry_q;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        alu_op   = OP_TST;
        alu_sel  = '0;
        alu_din  = '0;
        case (state)
            ST_IDLE: begin
                if (req) state_nx = ST_PASS_LO;
            end
            ST_PASS_LO: begin
                alu_op   = wide_q ? OP_DAD : op_q;
                alu_sel  = sel_lo_q;
                alu_din  = operand_q;
                state_nx = wide_q ? ST_PASS_HI : ST_DONE;
            end
            ST_PASS_HI: begin
                // High byte only needs the carry from the low pass folded in.
                alu_op   = carry_q ? OP_INC : OP_TST;
                alu_sel  = sel_hi_q;
                state_nx = ST_DONE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sr         <= SR_RESET;
            result     <= '0;
            page_cross <= 1'b0;
            carry_q    <= 1'b0;
            wide_q     <= 1'b0;
            op_q       <= OP_TST;
            sel_lo_q   <= '0;
            sel_hi_q   <= '0;
            operand_q  <= '0;
            mask_q     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                ST_IDLE: begin
                    // A direct status load and a new request may share a cycle;
                    // the load lands first and the op's flags merge on top later.
                    if (sr_we) sr <= with_u(sr_in);
                    if (req) begin
                        wide_q    <= wide;
                        op_q      <= op_in;
                        sel_lo_q  <= sel_in;
                        sel_hi_q  <= sel_hi;
                        operand_q <= operand;
                        mask_q    <= flag_mask;
                    end
                end
                ST_PASS_LO: begin
                    carry_q <= alu_flags[SR_C];
                    if (wide_q) begin
                        result[7:0] <= alu_dout;
                        page_cross  <= alu_flags[SR_C];
                    end else begin
                        result     <= {8'h00, alu_dout};
                        page_cross <= 1'b0;
                        sr         <= with_u((sr & ~mask_q) | (alu_flags & mask_q));
                    end
                end
                ST_PASS_HI: begin
                    result[15:8] <= alu_dout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_ctl.md
ALU_CTL -- requirements
Module: alu_ctl

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on posedge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port req, input, 1 bit: operation request, sampled only in IDLE.
REQ-004 SHALL have port wide, input, 1 bit: 1 selects two-pass 16-bit address add; 0 selects single-pass op.
REQ-005 SHALL have port op_in, input, 4 bits: ALU op code for a narrow operation.
REQ-006 SHALL have port sel_in, input, 3 bits: ALU operand select for the narrow pass or the wide low pass.
REQ-007 SHALL have port sel_hi, input, 3 bits: ALU operand select for the wide high pass.
REQ-008 SHALL have port operand, input, 8 bits: data_in for the narrow pass or the wide low pass.
REQ-009 SHALL have port flag_mask, input, 8 bits: status bits that a narrow op may update.
REQ-010 SHALL have port sr_we, input, 1 bit, and port sr_in, input, 8 bits: direct status load (PLP/flag instructions).
REQ-011 SHALL have port alu_op, output, 4 bits: op code driven to the ALU.
REQ-012 SHALL have port alu_sel, output, 3 bits: operand select driven to the ALU.
REQ-013 SHALL have port alu_din, output, 8 bits: data_in driven to the ALU.
REQ-014 SHALL have port alu_dout, input, 8 bits, and port alu_flags, input, 8 bits: ALU result and flags {N,V,0,0,0,0,Z,C}.
REQ-015 SHALL have port sr, output, 8 bits: architectural status register {N,V,1,B,D,I,Z,C}.
REQ-016 SHALL have port result, output, 16 bits: last captured result; narrow ops zero the upper byte.
REQ-017 SHALL have port busy, output, 1 bit, port done, output, 1 bit, and port page_cross, output, 1 bit.

Function
REQ-018 SHALL implement the FSM IDLE -> PASS_LO -> (wide ? PASS_HI : DONE), PASS_HI -> DONE, DONE -> IDLE.
REQ-019 SHALL, in IDLE with req=1 at posedge k, latch wide, op_in, sel_in, sel_hi, operand and flag_mask, and enter PASS_LO.
REQ-020 SHALL, in PASS_LO, drive alu_op = (wide ? OP_DAD : latched op), alu_sel = sel_in and alu_din = operand from registers, so they are stable before the ALU's negedge sample.
REQ-021 SHALL capture alu_dout into result[7:0] and alu_flags C into an internal carry at the posedge that ends PASS_LO.
REQ-022 SHALL, in PASS_HI, drive alu_op = OP_INC if the captured carry is 1, otherwise OP_TST, with alu_sel = sel_hi; it SHALL capture alu_dout into result[15:8].
REQ-023 SHALL set page_cross to the captured carry for wide ops, and to 0 for narrow ops.
REQ-024 SHALL update sr on a narrow-op capture as sr <= (sr & ~flag_mask) | (alu_flags & flag_mask), with bit 5 forced to 1.
REQ-025 SHALL leave sr unchanged on wide ops.
REQ-026 SHALL assert busy in PASS_LO, PASS_HI and DONE, and SHALL assert done for exactly one cycle in DONE.
REQ-027 SHALL have a latency from the req sample to done high of 2 cycles for narrow ops and 3 cycles for wide ops; req SHALL be ignored while busy.
REQ-028 SHALL drive alu_op = OP_TST, alu_sel = 0 and alu_din = 0 when in IDLE or DONE.
REQ-029 SHALL, on sr_we, load sr <= sr_in with bit 5 forced to 1 when in IDLE; sr_we while busy SHALL be ignored.
REQ-030 SHALL give sr_we priority over req when both occur in IDLE in the same cycle; the request is still accepted.

Reset
REQ-031 SHALL, on reset, force state IDLE, sr = 8'h24, result = 0, page_cross = 0, busy = 0, done = 0, and alu outputs to the REQ-028 values.
REQ-032 SHALL, if reset is asserted mid-operation, abort the operation, emit no done and leave sr at 8'h24.

Structure
REQ-033 SHALL take the op codes (OP_*), the SR_* bit indices and the status reset value 8'h24 from the shared k6502_defs include; no local redefinition.
REQ-034 SHALL be a single module with no sub-modules; the ALU is instantiated beside it by the CPU top.

Verification
REQ-035 SHALL be verified by this narrow scenario: sr=8'h24, OP_ADD, arg=8'h7F, operand=8'h01, flag_mask=8'hC3, with the real ALU attached -> result=16'h0080, sr=8'hE4, done at cycle k+2.
REQ-036 SHALL be verified by this wide, carry case: arg lo=8'hF0, operand=8'h20, high register=8'h12 -> result=16'h1310, page_cross=1, done at cycle k+3, sr unchanged.
REQ-037 SHALL be verified by this wide, no-carry case: arg lo=8'h10, operand=8'h05, high register=8'h12 -> result=16'h1215, page_cross=0.
REQ-038 SHALL be verified by this case: sr_we=1 with sr_in=8'h00 and req=1 in the same IDLE cycle -> sr=8'h20, the operation still runs, and its masked flags merge afterwards.
REQ-039 SHALL be verified by this case: req pulses while busy -> ignored, exactly one done per accepted request.
REQ-040 SHALL be verified by this case: reset asserted in PASS_HI -> next cycle IDLE, sr=8'h24, no done pulse.
